// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM state encoding,
// the wait-counter width and the default divider latency.
package hilo_pkg;

    localparam int DIV_LATENCY_DEF = 36;
    localparam int CNT_W           = 6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_regs (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_we_hi,
    input  logic        i_we_lo,
    input  logic [31:0] i_hi_d,
    input  logic [31:0] i_lo_d,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (i_we_hi) r_hi <= i_hi_d;
            if (i_we_lo) r_lo <= i_lo_d;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/hilo_ctrl.sv
// Sequences a divide between the pipeline and the multi-cycle divider, traps
// divide-by-zero before issue and services mthi/mtlo writes while idle.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_div_req,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_div_hi,
    input  logic [31:0] i_div_lo,
    output logic        o_div_start,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div0_exc,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV_LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_div_a;
    logic [31:0]      r_div_b;
    logic             r_done;
    logic             r_div0;
    logic             w_idle;
    logic             w_rt_zero;
    logic             w_accept;
    logic             w_trap;
    logic             w_start;
    logic             w_capture;
    logic             w_we_hi;
    logic             w_we_lo;
    logic [31:0]      w_hi_d;
    logic [31:0]      w_lo_d;

    assign w_idle    = (r_state == S_IDLE);
    assign w_rt_zero = (i_rt_val == '0);
    assign w_accept  = w_idle && i_div_req && !w_rt_zero;
    assign w_trap    = w_idle && i_div_req && w_rt_zero;

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_ISSUE;
            S_ISSUE: begin
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT:    if (r_cnt == C_LAST) w_next = S_CAPTURE;
            S_CAPTURE: begin
                w_capture = 1'b1;
                w_next    = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Counter is zeroed on the way into WAIT so each divide starts from 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            else                   r_cnt <= '0;
            if (w_accept) begin
                r_div_a <= i_rs_val;
                r_div_b <= i_rt_val;
            end
            r_done <= w_capture;
            r_div0 <= w_trap;
        end
    end

    // CAPTURE and IDLE are exclusive, so the divider result never races mthi/mtlo.
    assign w_we_hi = w_capture || (w_idle && i_mthi);
    assign w_we_lo = w_capture || (w_idle && i_mtlo);
    assign w_hi_d  = w_capture ? i_div_hi : i_wdata;
    assign w_lo_d  = w_capture ? i_div_lo : i_wdata;

    hilo_regs u_regs (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we_hi   (w_we_hi),
        .i_we_lo   (w_we_lo),
        .i_hi_d    (w_hi_d),
        .i_lo_d    (w_lo_d),
        .o_hi      (o_hi),
        .o_lo      (o_lo)
    );

    assign o_div_start = w_start;
    assign o_div_a     = r_div_a;
    assign o_div_b     = r_div_b;
    assign o_busy      = !w_idle || w_accept;
    assign o_done      = r_done;
    assign o_div0_exc  = r_div0;

endmodule
